// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates the register file write port between ALU (A) and load (B)
// writeback, with a zero-clear sweep after reset or on request.
module regfile_write_scheduler #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a_valid,
    input  logic [ADDR_W-1:0] req_a_reg,
    input  logic [DATA_W-1:0] req_a_data,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [ADDR_W-1:0] req_b_reg,
    input  logic [DATA_W-1:0] req_b_data,
    output logic              req_b_ready,
    input  logic              clear_start,
    output logic              busy,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_b;
    logic              run;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    // A clear request steals the cycle so no grant is lost when the sweep starts
    assign run         = (state == RUN) && !clear_start;
    assign grant_a     = run && req_a_valid && (!req_b_valid || last_b);
    assign grant_b     = run && req_b_valid && !grant_a;
    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;
    assign busy        = (state == CLEAR);
    assign sel_reg     = grant_a ? req_a_reg : req_b_reg;
    assign sel_data    = grant_a ? req_a_data : req_b_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            last_b    <= 1'b1;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else if (state == CLEAR) begin
            regWrite  <= 1'b1;
            writeReg  <= cnt;
            writeData <= '0;
            cnt       <= cnt + ADDR_W'(1);
            if (cnt == ADDR_W'(NUM_REGS - 2))
                state <= RUN;
        end else if (clear_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            regWrite <= 1'b0;
        end else if (grant_a || grant_b) begin
            last_b   <= grant_b;
            regWrite <= (sel_reg != ADDR_W'(ZERO_REG));
            // A zero-register write is swallowed; the address/data lines keep the last real write
            if (sel_reg != ADDR_W'(ZERO_REG)) begin
                writeReg  <= sel_reg;
                writeData <= sel_data;
            end
        end else begin
            regWrite <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed checks of clear sweep, arbitration, zero register and reset.
module tb_regfile_write_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_a_valid, req_b_valid, clear_start;
    logic [4:0]  req_a_reg, req_b_reg;
    logic [63:0] req_a_data, req_b_data;
    logic        req_a_ready, req_b_ready, busy, regWrite;
    logic [4:0]  writeReg;
    logic [63:0] writeData;
    int          n_cmp = 0;
    int          n_err = 0;

    regfile_write_scheduler dut (
        .clk(clk), .reset(reset),
        .req_a_valid(req_a_valid), .req_a_reg(req_a_reg), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_reg(req_b_reg), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
        .clear_start(clear_start), .busy(busy),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] wr, input logic [63:0] wd);
        check({tag, ".regWrite"}, 64'(regWrite), 64'(we));
        check({tag, ".writeReg"}, 64'(writeReg), 64'(wr));
        check({tag, ".writeData"}, writeData, wd);
    endtask

    initial begin
        reset = 1'b0;
        req_a_valid = 1'b0; req_a_reg = '0; req_a_data = '0;
        req_b_valid = 1'b0; req_b_reg = '0; req_b_data = '0;
        clear_start = 1'b0;

        // reset state
        step();
        check_out("reset", 1'b0, 5'd0, 64'd0);
        check("reset.busy", 64'(busy), 64'd1);
        check("reset.ready_a", 64'(req_a_ready), 64'd0);
        check("reset.ready_b", 64'(req_b_ready), 64'd0);

        // initial sweep, no requests
        reset = 1'b1;
        #1;
        check("sweep1.busy0", 64'(busy), 64'd1);
        for (int i = 0; i < 31; i++) begin
            step();
            check_out("sweep1", 1'b1, 5'(i), 64'd0);
            check("sweep1.busy", 64'(busy), 64'(i < 30));
        end
        step();
        check("sweep1.end_we", 64'(regWrite), 64'd0);
        check("sweep1.end_busy", 64'(busy), 64'd0);

        // A waits through CLEAR, then is granted in the first RUN cycle
        reset = 1'b0;
        #1;
        check_out("rst2", 1'b0, 5'd0, 64'd0);
        step();
        reset = 1'b1;
        req_a_valid = 1'b1; req_a_reg = 5'd3; req_a_data = 64'hDEAD;
        #1;
        check("wait.ready_a0", 64'(req_a_ready), 64'd0);
        for (int i = 0; i < 30; i++) begin
            step();
            check("wait.ready_a", 64'(req_a_ready), 64'd0);
        end
        step();
        check("run1.ready_a", 64'(req_a_ready), 64'd1);
        check("run1.busy", 64'(busy), 64'd0);
        check_out("run1.last_sweep", 1'b1, 5'd30, 64'd0);
        step();
        req_a_valid = 1'b0;
        check_out("a_write", 1'b1, 5'd3, 64'hDEAD);

        // zero-register write is accepted but not issued
        req_a_valid = 1'b1; req_a_reg = 5'd31; req_a_data = 64'hFFFF;
        #1;
        check("zero.ready_a", 64'(req_a_ready), 64'd1);
        check("zero.ready_b", 64'(req_b_ready), 64'd0);
        step();
        check("zero.we", 64'(regWrite), 64'd0);
        req_a_valid = 1'b0;
        req_b_valid = 1'b1; req_b_reg = 5'd5; req_b_data = 64'h55;
        #1;
        check("b5.ready_b", 64'(req_b_ready), 64'd1);
        step();
        check_out("b5", 1'b1, 5'd5, 64'h55);

        // both valid: last grant was B, so A leads and they alternate
        req_a_valid = 1'b1; req_a_reg = 5'd1; req_a_data = 64'h11;
        req_b_reg = 5'd2; req_b_data = 64'h22;
        #1;
        check("rr.ready_a0", 64'(req_a_ready), 64'd1);
        check("rr.ready_b0", 64'(req_b_ready), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k % 2 == 0) check_out("rr.a", 1'b1, 5'd1, 64'h11);
            else            check_out("rr.b", 1'b1, 5'd2, 64'h22);
            check("rr.ready_a", 64'(req_a_ready), 64'(k % 2 == 1));
            check("rr.ready_b", 64'(req_b_ready), 64'(k % 2 == 0));
        end
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        step();
        check_out("idle", 1'b0, 5'd2, 64'h22);

        // clear_start in RUN blocks B, sweep follows, mid-sweep pulse ignored
        req_b_valid = 1'b1; req_b_reg = 5'd7; req_b_data = 64'h77;
        clear_start = 1'b1;
        #1;
        check("clr.ready_b", 64'(req_b_ready), 64'd0);
        step();
        clear_start = 1'b0;
        check("clr.we", 64'(regWrite), 64'd0);
        check("clr.busy", 64'(busy), 64'd1);
        for (int i = 0; i < 31; i++) begin
            step();
            check_out("sweep2", 1'b1, 5'(i), 64'd0);
            check("sweep2.busy", 64'(busy), 64'(i < 30));
            check("sweep2.ready_b", 64'(req_b_ready), 64'(i == 30));
            clear_start = (i == 5);
        end
        step();
        req_b_valid = 1'b0;
        check_out("b7", 1'b1, 5'd7, 64'h77);

        // reset in the middle of a sweep restarts it from index 0
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            step();
            check("sweep3.reg", 64'(writeReg), 64'(i));
        end
        reset = 1'b0;
        #1;
        check_out("midrst", 1'b0, 5'd0, 64'd0);
        check("midrst.busy", 64'(busy), 64'd1);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 31; i++) begin
            step();
            check_out("sweep4", 1'b1, 5'(i), 64'd0);
        end
        step();
        check("sweep4.end_we", 64'(regWrite), 64'd0);
        check("sweep4.end_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
